// File: rtl/alu_seq_if.sv
// Request/response bundle for the execute-stage ALU.
// The master drives operands, the slave returns the result.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             illegal_o;

  modport master (
    output valid_i, ctrl_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o,
    input  zero_o, overflow_o, illegal_o
  );

  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i,
    output ready_o, valid_o, result_o,
    output zero_o, overflow_o, illegal_o
  );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked execute-stage ALU.
// Single-cycle logic/arith ops plus an iterative shift-add MUL.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_seq_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_NOR = 4'd12;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_nxt;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r;
  logic             ov;
  logic             ill;

  assign a    = bus.src1_i;
  assign b    = bus.src2_i;
  assign sum  = a + b;
  assign diff = a - b;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    r   = '0;
    ov  = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      (bus.ctrl_i == OP_AND): r = a & b;
      (bus.ctrl_i == OP_OR):  r = a | b;
      (bus.ctrl_i == OP_ADD): begin
        r  = sum;
        ov = (a[WIDTH-1] == b[WIDTH-1]) &&
             (sum[WIDTH-1] != a[WIDTH-1]);
      end
      (bus.ctrl_i == OP_SUB): begin
        r  = diff;
        ov = (a[WIDTH-1] != b[WIDTH-1]) &&
             (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // signed compare, immune to a-b overflow
      (bus.ctrl_i == OP_SLT):
        r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      (bus.ctrl_i == OP_NOR): r = ~(a | b);
      (bus.ctrl_i == OP_MUL): r = '0;
      default:                ill = 1'b1;
    endcase
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
      bus.illegal_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            if (bus.ctrl_i == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              bus.result_o   <= r;
              bus.zero_o     <= (r == '0);
              bus.overflow_o <= ov;
              bus.illegal_o  <= ill;
              state          <= DONE;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.result_o   <= acc_nxt;
            bus.zero_o     <= (acc_nxt == '0);
            bus.overflow_o <= 1'b0;
            bus.illegal_o  <= 1'b0;
            state          <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
